// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and default sizes for the DataMemory port arbiter.
//   - arb_state_e : arbiter FSM state (ARB = normal arbitration,
//                   LOCKED = loader holds exclusive ownership)
//   - owner_e     : which port owns a memory access / read return
//   - *_DEF       : default parameter values for the arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF        = 32;
  localparam int DATA_W_DEF        = 32;
  localparam int LDR_BURST_MAX_DEF = 4;
  localparam int STREAK_W          = 4;   // enough for a burst limit of up to 15

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_e;

endpackage

// File: rtl/rd_return_tag.sv
// rd_return_tag
//   Tags each read return with the port that issued the read one cycle
//   earlier. Generates the per-port rvalid and rdata.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     rd_owner          owner of the read granted this cycle (OWN_NONE if
//                       none, or if the granted access is a write)
//     mem_dout          DataMemory read data (valid the cycle after address)
//     cpu_rvalid/rdata  CPU read return
//     ldr_rvalid/rdata  loader read return
module rd_return_tag
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  owner_e            rd_owner,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata
);

  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0] ldr_hold_q, ldr_hold_d;

  // rvalid is a decode of the owner register only, so it is glitch-free and
  // can never be high for both ports at once.
  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign ldr_rvalid = (owner_q == OWN_LDR);

  // DataMemory presents the word during the return cycle, so the returning
  // port sees it directly then; the hold register keeps it afterwards until
  // the next return to the same port.
  assign cpu_rdata = cpu_rvalid ? mem_dout : cpu_hold_q;
  assign ldr_rdata = ldr_rvalid ? mem_dout : ldr_hold_q;

  always_comb begin
    owner_d    = rd_owner;
    cpu_hold_d = cpu_hold_q;
    ldr_hold_d = ldr_hold_q;
    if (cpu_rvalid) cpu_hold_d = mem_dout;
    if (ldr_rvalid) ldr_hold_d = mem_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      cpu_hold_q <= '0;
      ldr_hold_q <= '0;
    end else begin
      owner_q    <= owner_d;
      cpu_hold_q <= cpu_hold_d;
      ldr_hold_q <= ldr_hold_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port DataMemory between the multicycle CPU and a
//   program-loader/debug port. One winner per cycle (combinational grant),
//   read data returns one cycle later tagged to its owner.
//   Ports:
//     clk, rst_n                     clock, asynchronous active-low reset
//     cpu_req/we/addr/wdata          CPU request (held until granted)
//     cpu_gnt, cpu_rvalid, cpu_rdata CPU grant and read return
//     cpu_stall                      CPU must hold state / suppress writes
//     ldr_req/we/addr/wdata          loader request
//     ldr_gnt, ldr_rvalid, ldr_rdata loader grant and read return
//     ldr_lock, ldr_lock_ack         loader exclusive-ownership handshake
//     mem_addr/we/din, mem_dout      DataMemory port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int LDR_BURST_MAX = LDR_BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  input  logic              ldr_lock,
  output logic              ldr_lock_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(LDR_BURST_MAX);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                cpu_win, ldr_win;
  owner_e              rd_owner;

  // Next state simply follows the lock request in both directions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (ldr_lock)  state_d = LOCKED;
      LOCKED:  if (!ldr_lock) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Grant: the loader has priority, but after BURST_MAX consecutive wins
  // over a waiting CPU the CPU gets one slot.
  always_comb begin
    cpu_win = 1'b0;
    ldr_win = 1'b0;
    if (state_q == LOCKED) begin
      ldr_win = ldr_req;
    end else if (cpu_req && ldr_req) begin
      if (streak_q == BURST_MAX) cpu_win = 1'b1;
      else                       ldr_win = 1'b1;
    end else begin
      cpu_win = cpu_req;
      ldr_win = ldr_req;
    end
  end

  // streak counts loader wins that made the CPU wait.
  always_comb begin
    streak_d = streak_q;
    if (state_q == LOCKED || cpu_win || !cpu_req) begin
      streak_d = '0;
    end else if (ldr_win && streak_q != BURST_MAX) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  assign cpu_gnt      = cpu_win;
  assign ldr_gnt      = ldr_win;
  assign ldr_lock_ack = (state_q == LOCKED);

  // With no winner the CPU values stay on the bus; only mem_we is gated.
  assign mem_addr = ldr_win ? ldr_addr  : cpu_addr;
  assign mem_din  = ldr_win ? ldr_wdata : cpu_wdata;
  assign mem_we   = (cpu_win && cpu_we) || (ldr_win && ldr_we);

  // Only reads are tagged; writes finish at the grant edge.
  always_comb begin
    rd_owner = OWN_NONE;
    if (cpu_win && !cpu_we)      rd_owner = OWN_CPU;
    else if (ldr_win && !ldr_we) rd_owner = OWN_LDR;
  end

  // A CPU read granted this cycle has not delivered its data yet, so the
  // CPU also waits in its grant cycle and consumes the data the cycle after.
  assign cpu_stall = (cpu_req && !cpu_win) || (state_q == LOCKED) ||
                     (cpu_win && !cpu_we);

  rd_return_tag #(
    .DATA_W(DATA_W)
  ) u_rd_return_tag (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_owner  (rd_owner),
    .mem_dout  (mem_dout),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .ldr_rvalid(ldr_rvalid),
    .ldr_rdata (ldr_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int BMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [31:0] ldr_addr = '0, ldr_wdata = '0;
  logic        ldr_gnt, ldr_rvalid;
  logic [31:0] ldr_rdata;
  logic        ldr_lock = 1'b0;
  logic        ldr_lock_ack;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LDR_BURST_MAX(BMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .ldr_lock(ldr_lock), .ldr_lock_ack(ldr_lock_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Environment: synchronous-read DataMemory, word index = addr[7:0].
  logic        clr_mem = 1'b1;
  logic [31:0] bmem [256];
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) bmem[i] <= '0;
    end else if (mem_we) begin
      bmem[mem_addr[7:0]] <= mem_din;
    end
    mem_dout <= bmem[mem_addr[7:0]];
  end

  // Reference model state.
  logic [31:0] model_mem [256];
  bit          locked_m;
  int          streak_m;
  bit          cpu_rv_m, ldr_rv_m;
  logic [31:0] cpu_rd_m, ldr_rd_m;
  bit          e_c, e_l;

  // Last observed DUT values (for directed checks after a step).
  logic        o_cpu_gnt, o_ldr_gnt, o_cpu_stall, o_mem_we, o_cpu_rvalid, o_ldr_rvalid, o_ack;
  logic [31:0] o_cpu_rdata, o_ldr_rdata;

  int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    locked_m = 0; streak_m = 0;
    cpu_rv_m = 0; ldr_rv_m = 0;
    cpu_rd_m = '0; ldr_rd_m = '0;
  endtask

  // Expected combinational results for the current inputs, then compare.
  task automatic check_cycle(input string tag);
    bit          e_we, e_stall;
    logic [31:0] e_addr, e_din;
    e_c = 0; e_l = 0;
    if (locked_m)                 e_l = ldr_req;
    else if (cpu_req && ldr_req) begin
      if (streak_m == BMAX) e_c = 1; else e_l = 1;
    end else begin
      e_c = cpu_req; e_l = ldr_req;
    end
    e_we    = (e_c && cpu_we) || (e_l && ldr_we);
    e_addr  = e_l ? ldr_addr : cpu_addr;
    e_din   = e_l ? ldr_wdata : cpu_wdata;
    e_stall = (cpu_req && !e_c) || locked_m || (e_c && !cpu_we);
    chk({tag, ".cpu_gnt"},    32'(cpu_gnt),      32'(e_c));
    chk({tag, ".ldr_gnt"},    32'(ldr_gnt),      32'(e_l));
    chk({tag, ".mem_we"},     32'(mem_we),       32'(e_we));
    chk({tag, ".mem_addr"},   mem_addr,          e_addr);
    chk({tag, ".mem_din"},    mem_din,           e_din);
    chk({tag, ".cpu_stall"},  32'(cpu_stall),    32'(e_stall));
    chk({tag, ".cpu_rvalid"}, 32'(cpu_rvalid),   32'(cpu_rv_m));
    chk({tag, ".ldr_rvalid"}, 32'(ldr_rvalid),   32'(ldr_rv_m));
    chk({tag, ".cpu_rdata"},  cpu_rdata,         cpu_rd_m);
    chk({tag, ".ldr_rdata"},  ldr_rdata,         ldr_rd_m);
    chk({tag, ".lock_ack"},   32'(ldr_lock_ack), 32'(locked_m));
    o_cpu_gnt = cpu_gnt; o_ldr_gnt = ldr_gnt; o_cpu_stall = cpu_stall; o_mem_we = mem_we;
    o_cpu_rvalid = cpu_rvalid; o_ldr_rvalid = ldr_rvalid; o_ack = ldr_lock_ack;
    o_cpu_rdata = cpu_rdata; o_ldr_rdata = ldr_rdata;
  endtask

  // Advance the model across a clock edge using the grants decided above.
  task automatic model_edge();
    cpu_rv_m = e_c && !cpu_we;
    ldr_rv_m = e_l && !ldr_we;
    if (cpu_rv_m) cpu_rd_m = model_mem[cpu_addr[7:0]];
    if (ldr_rv_m) ldr_rd_m = model_mem[ldr_addr[7:0]];
    if (e_c && cpu_we) model_mem[cpu_addr[7:0]] = cpu_wdata;
    if (e_l && ldr_we) model_mem[ldr_addr[7:0]] = ldr_wdata;
    if (locked_m || e_c || !cpu_req) streak_m = 0;
    else if (e_l && streak_m < BMAX)  streak_m++;
    locked_m = ldr_lock;
  endtask

  task automatic step(input string tag,
                      input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                      input bit lr, input bit lw, input logic [31:0] la, input logic [31:0] ld,
                      input bit lk);
    @(negedge clk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
    ldr_lock = lk;
    #1;
    check_cycle(tag);
    $display("step %-10s cpu_req=%0b we=%0b gnt=%0b stall=%0b rv=%0b rd=%h | ldr_req=%0b we=%0b gnt=%0b rv=%0b rd=%h | lock=%0b ack=%0b",
             tag, cr, cw, cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, lr, lw, ldr_gnt, ldr_rvalid, ldr_rdata, lk, ldr_lock_ack);
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input string tag, input bit lk);
    step(tag, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, lk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cpu_req = 0; ldr_req = 0; ldr_lock = 0; cpu_we = 0; ldr_we = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst.ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    chk("rst.cpu_rdata",  cpu_rdata, 32'd0);
    chk("rst.ldr_rdata",  ldr_rdata, 32'd0);
    chk("rst.lock_ack",   32'(ldr_lock_ack), 32'd0);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  logic [9:0] pat;
  bit         lock_r;

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    model_reset();
    // Initial reset also clears the environment memory.
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr_mem = 1'b0;
    do_reset();

    // Loader preloads 0xDEADBEEF at 0x10, then the CPU read test from reset.
    step("preload", 0, 0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 0);
    do_reset();
    step("cpu_rd", 1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    chk("tp1.gnt_same_cycle", 32'(o_cpu_gnt), 32'd1);
    chk("tp1.stall_wait",     32'(o_cpu_stall), 32'd1);
    idle("cpu_rd_ret", 0);
    chk("tp1.rvalid", 32'(o_cpu_rvalid), 32'd1);
    chk("tp1.rdata",  o_cpu_rdata, 32'hDEADBEEF);
    chk("tp1.no_stall", 32'(o_cpu_stall), 32'd0);
    idle("cpu_rd_hold", 0);
    chk("tp1.rdata_hold", o_cpu_rdata, 32'hDEADBEEF);

    // Both requesting continuously: L,L,L,L,C,L,L,L,L,C.
    for (int i = 0; i < 10; i++) begin
      step("burst", 1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 0);
      pat[i] = o_cpu_gnt;
    end
    chk("tp2.pattern", 32'(pat), 32'(10'b1000010000));
    idle("burst_end", 0);

    // Loader lock with CPU waiting; loader write then read 0x55 @0x20.
    idle("lock_on", 1);
    step("lock_w", 1, 0, 32'h10, 0, 1, 1, 32'h20, 32'h55, 1);
    chk("tp3.ack", 32'(o_ack), 32'd1);
    chk("tp3.cpu_blocked", 32'(o_cpu_gnt), 32'd0);
    step("lock_r", 1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 1);
    step("lock_ret", 1, 0, 32'h10, 0, 0, 0, 0, 0, 1);
    chk("tp3.ldr_rdata", o_ldr_rdata, 32'h55);
    chk("tp3.stall", 32'(o_cpu_stall), 32'd1);
    step("unlock", 1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    step("cpu_after", 1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    chk("tp3.cpu_gnt_after_unlock", 32'(o_cpu_gnt), 32'd1);
    idle("cpu_after_ret", 0);
    chk("tp3.cpu_rdata", o_cpu_rdata, 32'h55);

    // CPU read granted in the cycle the lock rises.
    step("lock_edge", 1, 0, 32'h10, 0, 0, 0, 0, 0, 1);
    chk("tp4.gnt", 32'(o_cpu_gnt), 32'd1);
    idle("lock_edge_ret", 1);
    chk("tp4.rvalid_locked", 32'(o_cpu_rvalid), 32'd1);
    chk("tp4.rdata", o_cpu_rdata, 32'hDEADBEEF);
    chk("tp4.ack", 32'(o_ack), 32'd1);
    idle("unlock2", 0);

    // Reset pulse while a loader read is pending.
    @(negedge clk);
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h10; cpu_req = 0; ldr_lock = 0;
    #1;
    check_cycle("rst_mid");
    rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    ldr_req = 0;
    @(negedge clk);
    chk("tp5.ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    chk("tp5.ldr_rdata",  ldr_rdata, 32'd0);
    chk("tp5.cpu_rdata",  cpu_rdata, 32'd0);
    chk("tp5.ack",        32'(ldr_lock_ack), 32'd0);
    rst_n = 1'b1;
    $display("reset pulse during loader read released");
    idle("rst_after", 0);
    chk("tp5.no_rvalid_after", 32'(o_ldr_rvalid), 32'd0);

    // Alternating CPU write / loader read at 0x4.
    step("alt_cw", 1, 1, 32'h4, 32'hA5, 0, 0, 0, 0, 0);
    chk("tp6.we_cpu", 32'(o_mem_we), 32'd1);
    step("alt_lr", 0, 0, 0, 0, 1, 0, 32'h4, 0, 0);
    chk("tp6.we_ldr", 32'(o_mem_we), 32'd0);
    idle("alt_ret", 0);
    chk("tp6.rvalid", 32'(o_ldr_rvalid), 32'd1);
    chk("tp6.rdata", o_ldr_rdata, 32'hA5);

    // Randomized traffic against the model.
    lock_r = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) lock_r = ~lock_r;
      step("rand",
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           lock_r);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
